cci_wordline_stream: RTL and testbench
======================================

// Module: cci_wordline_stream
// PURPOSE
//  Streaming cell-to-cell interference (CCI) stage for the channel model, replacing the fixed 16-cell
//  buffer -> CCI -> parallel-to-serial chain with one parametrised block. Sits between RTN_distortion
//  and the retention stage. Buffers one word line (WL k, victim) plus the next (WL k+1, aggressor) and
//  emits WL k serially with vertical and diagonal coupling added. Valid/ready on both sides; flush/bypass.
// PARAMETERS
//  N_CELLS    16     cells per word line (>=2)
//  VTH_W      16     Vth field width, unsigned mV, in_data[DATA_W-1 -: VTH_W]
//  DATA_W     32     word width; low DATA_W-VTH_W bits are a tag passed through unchanged
//  FRAC       12     fractional bits of coupling coefficients
//  GAMMA_Y    262    vertical coupling, Q0.FRAC (0.064)
//  GAMMA_XY   20     diagonal coupling, Q0.FRAC (~0.0048)
//  ERASE_REF  1100   erased-state reference Vth, mV
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous, active-high
//  cci_enable   in   1       0 = pass victim Vth unchanged (bypass), sampled per output cell
//  flush        in   1       1-cycle pulse: drain held WL with no aggressor (zero interference)
//  in_valid     in   1       input cell valid
//  in_ready     out  1       block accepts cell this cycle
//  in_data      in   DATA_W  cell word: {Vth, tag}
//  out_valid    out  1       out_data valid
//  out_ready    in   1       downstream accepts
//  out_data     out  DATA_W  {Vth after CCI, tag of victim}
//  out_last     out  1       high with last cell (index N_CELLS-1) of a word line
//  busy         out  1       state != FILL_FIRST or any cell held
//  wl_count     out  16      word lines emitted, wraps 65535 -> 0
// BEHAVIOUR
//  - Reset: state FILL_FIRST, cell index 0, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0,
//    wl_count=0, both buffers invalid. Reset mid-drain discards all held data; no partial WL emitted.
//  - Transfer occurs on in_valid&&in_ready / out_valid&&out_ready; held outputs stable while stalled.
//  - FILL_FIRST: cells written to victim buffer in order 0..N-1; after cell N-1 -> FILL_AGG.
//  - FILL_AGG: cells written to aggressor buffer; after cell N-1 -> DRAIN. in_ready=1 in both fills.
//  - DRAIN: in_ready=0. out_valid rises the cycle after entry with cell 0; each handshake advances to
//    next cell on the following cycle (one cell/cycle at full throughput). After cell N-1 handshake:
//    aggressor buffer becomes victim (pointer swap, no copy), wl_count++, -> FILL_AGG.
//  - flush in FILL_AGG with zero aggressor cells received: -> DRAIN_FLUSH (same as DRAIN, interference
//    forced 0), then -> FILL_FIRST. flush in FILL_AGG mid-fill: partial aggressor discarded, same path.
//    flush in FILL_FIRST / DRAIN / DRAIN_FLUSH ignored. flush and in_valid in same cycle: cell accepted
//    only if not FILL_AGG; in FILL_AGG flush wins and in_ready=0 that cycle.
//  - Arithmetic for victim cell i: dV(j) = max(0, Vagg(j) - ERASE_REF), VTH_W bits.
//    acc = GAMMA_Y*dV(i) + GAMMA_XY*(dV(i-1) + dV(i+1)); missing neighbours at i=0 / i=N-1 count as 0.
//    acc width >= VTH_W+FRAC+2, unsigned; delta = acc >> FRAC (truncate).
//    Vout = min(Vvictim + delta, 2^VTH_W-1) (saturate). cci_enable=0 or DRAIN_FLUSH: Vout = Vvictim.
//  - out_last = (index == N_CELLS-1) qualified by out_valid. Tag bits always from victim cell.
//  - Output registered; compute path is one multiply-accumulate per cycle, no cross-cell state.
// TESTING (N_CELLS=4, defaults otherwise)
//  1. Reset, stream WL0 all 2000, WL1 all 1100 -> WL0 out 2000,2000,2000,2000; out_last on 4th; wl_count=1.
//  2. WL0 all 2000, WL1 all 3100 (dV=2000) -> out 2137,2147,2147,2137.
//  3. WL1 all 900 (below ERASE_REF) -> dV clamped 0, out = victim 2000 x4; same data with cci_enable=0
//     and WL1=3100 -> 2000 x4.
//  4. Victim 65500, WL1 all 3100 -> all outputs 65535 (saturation); tags 0x0000..0x0003 preserved.
//  5. out_ready toggled 1,0,0,1 in DRAIN -> out_data held during stall, no cell dropped/duplicated,
//     in_ready=0 throughout; three WLs back-to-back -> WL1 emitted with WL2 as aggressor, wl_count=2.
//  6. flush after WL0 only -> WL0 out unchanged, state FILL_FIRST; reset asserted on 2nd drain cell ->
//     next cycle out_valid=0, wl_count=0, in_ready=1.

Source files
------------

// File: rtl/cci_wordline_stream.sv
// cci_wordline_stream: buffers a victim and an aggressor word line and
// streams the victim out with vertical/diagonal coupling added.
module cci_wordline_stream #(
  parameter int N_CELLS   = 16,
  parameter int VTH_W     = 16,
  parameter int DATA_W    = 32,
  parameter int FRAC      = 12,
  parameter int GAMMA_Y   = 262,
  parameter int GAMMA_XY  = 20,
  parameter int ERASE_REF = 1100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cci_enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       wl_count
);

  localparam int IDX_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int TAG_W = DATA_W - VTH_W;
  localparam int ACC_W = VTH_W + FRAC + 2;
  localparam int DLT_W = ACC_W - FRAC;
  localparam int SUM_W = DLT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  typedef enum logic [1:0] {
    FILL_FIRST,
    FILL_AGG,
    DRAIN,
    DRAIN_FLUSH
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              vsel;
  logic [DATA_W-1:0] mem [2][N_CELLS];

  logic              wr_en;
  logic              wr_buf;
  logic              at_last;
  logic [IDX_W-1:0]  idx_m;
  logic [IDX_W-1:0]  idx_p;
  logic [DATA_W-1:0] vic_word;
  logic [VTH_W-1:0]  dv_c;
  logic [VTH_W-1:0]  dv_l;
  logic [VTH_W-1:0]  dv_r;
  logic [ACC_W-1:0]  acc;
  logic [DLT_W-1:0]  delta;
  logic [SUM_W-1:0]  sum;
  logic [VTH_W-1:0]  vth_out;
  logic [DATA_W-1:0] out_next;
  logic              apply;

  // Aggressor Vth excess above the erased reference, clamped at zero.
  function automatic logic [VTH_W-1:0] excess(input logic [VTH_W-1:0] v);
    logic [VTH_W-1:0] r;
    r = '0;
    if (v > VTH_W'(ERASE_REF))
      r = v - VTH_W'(ERASE_REF);
    return r;
  endfunction

  // Flush wins over an incoming cell while the aggressor is filling.
  always_comb begin
    in_ready = (state == FILL_FIRST) ||
               ((state == FILL_AGG) && !flush);
    wr_en    = in_valid && in_ready;
    wr_buf   = (state == FILL_FIRST) ? vsel : ~vsel;
    at_last  = (idx == LAST_IDX);
    busy     = (state != FILL_FIRST) || (idx != '0);
  end

  // Coupling for the victim cell at idx from its aggressor neighbours.
  always_comb begin
    idx_m    = idx - IDX_W'(1);
    idx_p    = idx + IDX_W'(1);
    vic_word = mem[vsel][idx];
    dv_c     = excess(mem[~vsel][idx][DATA_W-1 -: VTH_W]);
    dv_l     = '0;
    dv_r     = '0;
    if (idx != '0)
      dv_l = excess(mem[~vsel][idx_m][DATA_W-1 -: VTH_W]);
    if (!at_last)
      dv_r = excess(mem[~vsel][idx_p][DATA_W-1 -: VTH_W]);
    acc = ACC_W'(GAMMA_Y) * ACC_W'(dv_c) +
          ACC_W'(GAMMA_XY) * (ACC_W'(dv_l) + ACC_W'(dv_r));
    apply = cci_enable && (state == DRAIN);
    delta = apply ? DLT_W'(acc >> FRAC) : '0;
    sum   = SUM_W'(vic_word[DATA_W-1 -: VTH_W]) + SUM_W'(delta);
    if (sum > SUM_W'({VTH_W{1'b1}}))
      vth_out = '1;
    else
      vth_out = sum[VTH_W-1:0];
    out_next = {vth_out, vic_word[TAG_W-1:0]};
  end

  // Cell storage; the two halves swap roles instead of copying.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_buf][idx] <= in_data;
  end

  // Fill / drain sequencer with registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL_FIRST;
      idx       <= '0;
      vsel      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      wl_count  <= '0;
    end else begin
      unique case (state)
        FILL_FIRST: begin
          if (wr_en) begin
            if (at_last) begin
              idx   <= '0;
              state <= FILL_AGG;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FILL_AGG: begin
          if (flush) begin
            idx   <= '0;
            state <= DRAIN_FLUSH;
          end else if (wr_en) begin
            if (at_last) begin
              idx   <= '0;
              state <= DRAIN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DRAIN, DRAIN_FLUSH: begin
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            wl_count  <= wl_count + 16'd1;
            idx       <= '0;
            if (state == DRAIN) begin
              vsel  <= ~vsel;
              state <= FILL_AGG;
            end else begin
              state <= FILL_FIRST;
            end
          end else if (!out_valid || out_ready) begin
            out_valid <= 1'b1;
            out_data  <= out_next;
            out_last  <= at_last;
            idx       <= at_last ? '0 : idx + IDX_W'(1);
          end
        end
        default: state <= FILL_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_cci_wordline_stream.sv
// tb_cci_wordline_stream: directed and randomized word-line streams
// checked against an arithmetic model of the coupling rules.
module tb_cci_wordline_stream;

  localparam int N = 4;

  typedef logic [15:0] wl_t [N];

  logic        clk = 1'b0;
  logic        reset;
  logic        cci_enable;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] wl_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_wl   = 0;

  wl_t cur_v, cur_t;
  wl_t c2000, c1100, c3100, c900, c65500, c65535, t0, t4, ra, rt, rexp;
  wl_t ex2;

  cci_wordline_stream #(.N_CELLS(N)) dut (
    .clk(clk),
    .reset(reset),
    .cci_enable(cci_enable),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .wl_count(wl_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output of one word line from the coupling rules.
  function automatic wl_t model_wl(wl_t v, wl_t a, bit en, bit fl);
    wl_t r;
    int dv [N];
    for (int j = 0; j < N; j++)
      dv[j] = (int'(a[j]) > 1100) ? int'(a[j]) - 1100 : 0;
    for (int i = 0; i < N; i++) begin
      int nb, d, s;
      nb = ((i > 0) ? dv[i-1] : 0) + ((i < N-1) ? dv[i+1] : 0);
      d  = (262 * dv[i] + 20 * nb) / 4096;
      s  = int'(v[i]) + ((en && !fl) ? d : 0);
      r[i] = (s > 65535) ? 16'hFFFF : 16'(s);
    end
    return r;
  endfunction

  function automatic wl_t rand_wl();
    wl_t r;
    for (int i = 0; i < N; i++)
      r[i] = ($urandom_range(0, 3) == 0) ?
             16'($urandom_range(60000, 65535)) :
             16'($urandom_range(500, 6000));
    return r;
  endfunction

  function automatic wl_t rand_tags();
    wl_t r;
    for (int i = 0; i < N; i++)
      r[i] = 16'($urandom);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    exp_wl = 0;
  endtask

  task automatic send_cell(logic [15:0] v, logic [15:0] t);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {v, t};
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready)
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    else
      @(posedge clk);
  endtask

  task automatic fill(wl_t v, wl_t t);
    for (int i = 0; i < N; i++)
      send_cell(v[i], t[i]);
  endtask

  // mode 0: always ready, 1: ready 1,0,0,1 repeating, 2: random
  task automatic drain(wl_t ev, wl_t et, int mode);
    int k, cyc;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = pat[cyc % 4];
      else                out_ready = 1'($urandom_range(0, 1));
      if (out_valid) begin
        check($sformatf("out_data[%0d]", k), out_data, {ev[k], et[k]});
        check($sformatf("out_last[%0d]", k), 32'(out_last),
              32'(k == N - 1));
        check("in_ready_drain", 32'(in_ready), 32'd0);
        if (out_ready) k++;
      end
      cyc++;
    end
    if (k < N)
      check("drain_timeout", k, N);
    @(negedge clk);
    exp_wl = (exp_wl + 1) % 65536;
    check("wl_count", 32'(wl_count), 32'(exp_wl));
  endtask

  task automatic start(wl_t v, wl_t t);
    fill(v, t);
    cur_v = v;
    cur_t = t;
  endtask

  task automatic pass_wl_exp(wl_t av, wl_t at, wl_t ev, int mode);
    fill(av, at);
    drain(ev, cur_t, mode);
    cur_v = av;
    cur_t = at;
  endtask

  task automatic pass_wl(wl_t av, wl_t at, int mode);
    wl_t ev;
    ev = model_wl(cur_v, av, cci_enable, 1'b0);
    pass_wl_exp(av, at, ev, mode);
  endtask

  // Flush raised together with a valid cell: flush must win.
  task automatic do_flush(int mode);
    wl_t ev;
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    #1;
    check("in_ready_flush", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    ev = model_wl(cur_v, cur_v, cci_enable, 1'b1);
    drain(ev, cur_t, mode);
    check("busy_after_flush", 32'(busy), 32'd0);
  endtask

  initial begin
    bit  hit;
    int  cnt;
    reset      = 1'b1;
    cci_enable = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < N; i++) begin
      c2000[i]  = 16'd2000;
      c1100[i]  = 16'd1100;
      c3100[i]  = 16'd3100;
      c900[i]   = 16'd900;
      c65500[i] = 16'd65500;
      c65535[i] = 16'd65535;
      t0[i]     = 16'(i);
      t4[i]     = 16'(i + 4);
    end
    ex2 = '{16'd2137, 16'd2147, 16'd2147, 16'd2137};

    repeat (2) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wl_count", 32'(wl_count), 32'd0);

    start(c2000, t0);
    pass_wl_exp(c1100, t4, c2000, 0);

    do_flush(0);
    start(c2000, t0);
    pass_wl_exp(c3100, t4, ex2, 0);

    do_flush(0);
    start(c2000, t0);
    pass_wl_exp(c900, t4, c2000, 0);

    do_flush(0);
    start(c2000, t0);
    cci_enable = 1'b0;
    pass_wl_exp(c3100, t4, c2000, 0);
    cci_enable = 1'b1;

    do_flush(0);
    start(c65500, t0);
    pass_wl_exp(c3100, t4, c65535, 0);

    do_reset();
    start(rand_wl(), rand_tags());
    pass_wl(rand_wl(), rand_tags(), 1);
    pass_wl(rand_wl(), rand_tags(), 1);

    for (int it = 0; it < 6; it++) begin
      cci_enable = 1'($urandom_range(0, 1));
      pass_wl(rand_wl(), rand_tags(), 2);
    end
    cci_enable = 1'b1;
    ra = rand_wl();
    rt = rand_tags();
    send_cell(ra[0], rt[0]);
    send_cell(ra[1], rt[1]);
    do_flush(2);
    start(rand_wl(), rand_tags());
    pass_wl(rand_wl(), rand_tags(), 2);

    do_reset();
    start(c2000, t0);
    do_flush(0);

    do_reset();
    ra = rand_wl();
    start(ra, t0);
    fill(c3100, t4);
    rexp = model_wl(ra, c3100, 1'b1, 1'b0);
    hit = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (out_valid) begin
        check("pre_rst_data", out_data, {rexp[cnt], t0[cnt]});
        if (cnt == 1) begin
          reset = 1'b1;
          hit   = 1'b1;
        end
        cnt++;
      end
    end
    if (!hit)
      check("pre_rst_timeout", cnt, 2);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_wl_count", 32'(wl_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
